// File: rtl/jtframe_ps2_host_tx.sv
// jtframe_ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send, ACK check and timeout
module jtframe_ps2_host_tx #(
    parameter int CLK_KHZ    = 48000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int INH = INHIBIT_US * CLK_KHZ / 1000;
    localparam int TO  = TIMEOUT_MS * CLK_KHZ;
    localparam int CW  = $clog2(TO + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INH - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TO - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERR} state_t;

    state_t        state;
    logic [1:0]    clk_q, data_q;
    logic          clk_last;
    logic [9:0]    frame;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cnt;
    logic          fall, timed;

    assign fall  = clk_last & ~clk_q[1];
    assign timed = state inside {RTS, SHIFT, ACK, WAIT_IDLE};

    // synchronise the open-collector lines; idle level is high so reset to 1 avoids a false fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q    <= 2'b11;
            data_q   <= 2'b11;
            clk_last <= 1'b1;
        end else begin
            clk_q    <= {clk_q[0], ps2_clk_i};
            data_q   <= {data_q[0], ps2_data_i};
            clk_last <= clk_q[1];
        end
    end

    // inhibit, request-to-send, shift on device clock falls, ACK check and timeout abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (timed && cnt == TO_LAST) begin
                state       <= ERR;
                error       <= 1'b1;
                busy        <= 1'b0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end else begin
                if (timed) cnt <= cnt + 1'b1;
                case (state)
                    IDLE: if (tx_start) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        cnt        <= '0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                    INHIBIT: if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        bit_cnt     <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        state       <= RTS;
                    end else cnt <= cnt + 1'b1;
                    RTS: if (fall) begin
                        ps2_data_oe <= ~frame[0];
                        frame       <= frame >> 1;
                        bit_cnt     <= 4'd1;
                        state       <= SHIFT;
                    end
                    SHIFT: if (fall) begin
                        if (bit_cnt == 4'd10) state <= ACK;
                        else begin
                            ps2_data_oe <= ~frame[0];
                            frame       <= frame >> 1;
                            bit_cnt     <= bit_cnt + 4'd1;
                        end
                    end
                    ACK: if (fall) begin
                        if (data_q[1]) begin
                            state       <= ERR;
                            error       <= 1'b1;
                            busy        <= 1'b0;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b0;
                        end else state <= WAIT_IDLE;
                    end
                    WAIT_IDLE: if (clk_q[1] && data_q[1]) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
